mult_seq_param: RTL

Parametrised sequential unsigned multiplier that combines controller and datapath in one block. It sits behind the same GO/START handshake as the existing multiplier controller. It is generalised to any operand width, and a build-time MODE selects between two iteration schemes:
- MODE=0: single-cycle-per-iteration repeated addition.
- MODE=1: shift-add with early termination.

Operands are captured on GO. The product is published through a result register with a one-cycle DONE pulse.

---
 rtl/mult_seq_param.sv | 117 +++++++++++
 1 files changed

// File: rtl/mult_seq_param.sv
// rtl/mult_seq_param.sv - parametrised sequential unsigned multiplier (repeated-add or shift-add)
module mult_seq_param #(
  parameter int WIDTH = 3,
  parameter int MODE  = 0
) (
  input  logic               SYS_CLOCK,
  input  logic               SYS_RESET,
  input  logic               GO,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               START,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] PRODUCT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_sh;
  logic [2*WIDTH-1:0] f_reg;
  logic               done_r;
  logic               run_last;

  // Last RUN cycle: repeated-add counts to B-1, shift-add stops once no multiplier bits remain.
  always_comb begin
    run_last = 1'b0;
    if (MODE == 0) begin
      run_last = (cnt == (b_reg - WIDTH'(1)));
    end else begin
      run_last = ((b_reg >> 1) == '0);
    end
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (GO) begin
          state_next = ((A == '0) || (B == '0)) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (run_last) begin
          state_next = S_FINISH;
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    START = (state == S_IDLE);
    BUSY  = ~START;
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (SYS_RESET) begin
      a_reg  <= '0;
      b_reg  <= '0;
      cnt    <= '0;
      acc    <= '0;
      a_sh   <= '0;
      f_reg  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == S_FINISH);
      case (state)
        S_IDLE: begin
          if (GO) begin
            a_reg <= A;
            b_reg <= B;
            cnt   <= '0;
            acc   <= '0;
            a_sh  <= {{WIDTH{1'b0}}, A};
          end
        end
        S_RUN: begin
          if (MODE == 0) begin
            acc <= acc + {{WIDTH{1'b0}}, a_reg};
            cnt <= cnt + WIDTH'(1);
          end else begin
            if (b_reg[0]) begin
              acc <= acc + a_sh;
            end
            a_sh  <= a_sh << 1;
            b_reg <= b_reg >> 1;
          end
        end
        S_FINISH: f_reg <= acc;
        default: ;
      endcase
    end
  end

  assign DONE    = done_r;
  assign PRODUCT = f_reg;

endmodule
